// File: rtl/paint_scheduler_pkg.sv
// Shared types and constants for the box-painter scheduler.
package paint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE
  } state_e;

  localparam int unsigned DEF_CELL_PX = 24;
  localparam int unsigned DEF_X_ORG   = 200;
  localparam int unsigned DEF_Y_ORG   = 0;
  localparam int unsigned DEF_NCOLS   = 10;
  localparam int unsigned DEF_NROWS   = 20;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COLOR_W = 9;

  localparam logic [COLOR_W-1:0] COL_BG    = 9'h1FF;
  localparam logic [COLOR_W-1:0] COL_PIECE = 9'h1C7;

endpackage

// File: rtl/paint_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or after start_ptr.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   start_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(start_ptr) + k) % NREQ);
      if (!gnt_valid && req[cand]) begin
        gnt_valid     = 1'b1;
        gnt_oh[cand]  = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/paint_scheduler.sv
// Arbitrates requester and board-clear jobs onto the single box painter.
module paint_scheduler
  import paint_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CELL_PX = DEF_CELL_PX,
  parameter int unsigned X_ORG   = DEF_X_ORG,
  parameter int unsigned Y_ORG   = DEF_Y_ORG,
  parameter int unsigned NCOLS   = DEF_NCOLS,
  parameter int unsigned NROWS   = DEF_NROWS
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [COL_W*NREQ-1:0]   req_col,
  input  logic [ROW_W*NREQ-1:0]   req_row,
  input  logic [COLOR_W*NREQ-1:0] req_color,
  output logic [NREQ-1:0]         ack,
  input  logic                    clear_start,
  input  logic [COLOR_W-1:0]      clear_color,
  output logic                    clear_busy,
  output logic                    rnd_start,
  output logic [X_W-1:0]          rnd_x0,
  output logic [Y_W-1:0]          rnd_y0,
  output logic [COLOR_W-1:0]      rnd_color,
  input  logic                    rnd_busy,
  input  logic                    rnd_done,
  output logic                    idle,
  output logic                    err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d, gnt_idx_q, gnt_idx_d;
  logic                 gnt_clr_q, gnt_clr_d;
  logic                 clr_busy_q, clr_busy_d;
  logic [COL_W-1:0]     clr_col_q, clr_col_d;
  logic [ROW_W-1:0]     clr_row_q, clr_row_d;
  logic [COLOR_W-1:0]   clr_color_q, clr_color_d;
  logic                 rnd_start_q, rnd_start_d;
  logic [X_W-1:0]       rnd_x0_q, rnd_x0_d;
  logic [Y_W-1:0]       rnd_y0_q, rnd_y0_d;
  logic [COLOR_W-1:0]   rnd_color_q, rnd_color_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic                 idle_q, idle_d, err_q, err_d;

  logic [NREQ-1:0]      arb_oh;
  logic [PW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [COL_W-1:0]     sel_col, cell_col;
  logic [ROW_W-1:0]     sel_row, cell_row;
  logic [COLOR_W-1:0]   sel_color;
  logic                 sel_oor;

  // ptr_q holds the next search start (last grant + 1), so a reset value of 0 favours requester 0.
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req       (req),
    .start_ptr (ptr_q),
    .gnt_oh    (arb_oh),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    sel_col   = req_col[int'(arb_idx)*COL_W +: COL_W];
    sel_row   = req_row[int'(arb_idx)*ROW_W +: ROW_W];
    sel_color = req_color[int'(arb_idx)*COLOR_W +: COLOR_W];
    sel_oor   = (32'(sel_col) >= NCOLS) || (32'(sel_row) >= NROWS);
    cell_col  = clr_busy_q ? clr_col_q : sel_col;
    cell_row  = clr_busy_q ? clr_row_q : sel_row;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_clr_d   = gnt_clr_q;
    clr_busy_d  = clr_busy_q;
    clr_col_d   = clr_col_q;
    clr_row_d   = clr_row_q;
    clr_color_d = clr_color_q;
    rnd_start_d = 1'b0;
    rnd_x0_d    = rnd_x0_q;
    rnd_y0_d    = rnd_y0_q;
    rnd_color_d = rnd_color_q;
    ack_d       = '0;
    err_d       = err_q;

    if (clear_start && !clr_busy_q) begin
      clr_busy_d  = 1'b1;
      clr_color_d = clear_color;
      clr_col_d   = '0;
      clr_row_d   = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rnd_busy && (clr_busy_q || arb_valid)) begin
          rnd_x0_d    = X_W'(X_ORG + CELL_PX * 32'(cell_col));
          rnd_y0_d    = Y_W'(Y_ORG + CELL_PX * 32'(cell_row));
          rnd_color_d = clr_busy_q ? clr_color_q : sel_color;
          gnt_clr_d   = clr_busy_q;
          if (!clr_busy_q) gnt_idx_d = arb_idx;
          if (!clr_busy_q && sel_oor) begin
            ack_d   = arb_oh;
            err_d   = 1'b1;
            state_d = ST_RETIRE;
          end else begin
            rnd_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rnd_done) begin
          state_d = ST_RETIRE;
          if (gnt_clr_q) begin
            if (clr_col_q == COL_W'(NCOLS - 1)) begin
              clr_col_d = '0;
              if (clr_row_q == ROW_W'(NROWS - 1)) begin
                clr_row_d  = '0;
                clr_busy_d = 1'b0;
              end else begin
                clr_row_d = clr_row_q + 1'b1;
              end
            end else begin
              clr_col_d = clr_col_q + 1'b1;
            end
          end else begin
            ack_d = NREQ'(1) << gnt_idx_q;
          end
        end
      end
      ST_RETIRE: begin
        if (!gnt_clr_q) ptr_d = (gnt_idx_q == PW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    idle_d = (state_d == ST_IDLE) && !clr_busy_d && !(|req);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_clr_q   <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_col_q   <= '0;
      clr_row_q   <= '0;
      clr_color_q <= '0;
      rnd_start_q <= 1'b0;
      rnd_x0_q    <= '0;
      rnd_y0_q    <= '0;
      rnd_color_q <= '0;
      ack_q       <= '0;
      idle_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_clr_q   <= gnt_clr_d;
      clr_busy_q  <= clr_busy_d;
      clr_col_q   <= clr_col_d;
      clr_row_q   <= clr_row_d;
      clr_color_q <= clr_color_d;
      rnd_start_q <= rnd_start_d;
      rnd_x0_q    <= rnd_x0_d;
      rnd_y0_q    <= rnd_y0_d;
      rnd_color_q <= rnd_color_d;
      ack_q       <= ack_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  assign ack        = ack_q;
  assign clear_busy = clr_busy_q;
  assign rnd_start  = rnd_start_q;
  assign rnd_x0     = rnd_x0_q;
  assign rnd_y0     = rnd_y0_q;
  assign rnd_color  = rnd_color_q;
  assign idle       = idle_q;
  assign err        = err_q;

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler with a fixed-latency painter model.
module tb_paint_scheduler;
  import paint_pkg::*;

  localparam int P = 10;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic [3:0]  req      = '0;
  logic [15:0] req_col  = '0;
  logic [19:0] req_row  = '0;
  logic [35:0] req_color = '0;
  logic [3:0]  ack;
  logic        clear_start = 1'b0;
  logic [8:0]  clear_color = '0;
  logic        clear_busy;
  logic        rnd_start;
  logic [9:0]  rnd_x0;
  logic [8:0]  rnd_y0;
  logic [8:0]  rnd_color;
  logic        rnd_busy = 1'b0;
  logic        rnd_done = 1'b0;
  logic        idle;
  logic        err;

  paint_scheduler #(.NREQ(4), .CELL_PX(24), .X_ORG(200), .Y_ORG(0), .NCOLS(10), .NROWS(20)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req), .req_col(req_col), .req_row(req_row),
    .req_color(req_color), .ack(ack), .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .rnd_start(rnd_start), .rnd_x0(rnd_x0), .rnd_y0(rnd_y0),
    .rnd_color(rnd_color), .rnd_busy(rnd_busy), .rnd_done(rnd_done), .idle(idle), .err(err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pcnt = 0;
  int busy_viol = 0;
  int cb_fall_cyc = -1;
  logic cb_prev = 1'b0;
  int st_x[$], st_y[$], st_c[$], st_cyc[$], ak_v[$], ak_cyc[$];

  // Painter model and event log, evaluated on the falling edge.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (!resetn) begin
      rnd_busy = 1'b0;
      rnd_done = 1'b0;
      pcnt     = 0;
      cb_prev  = 1'b0;
    end else begin
      rnd_done = 1'b0;
      if (rnd_busy) begin
        pcnt++;
        if (pcnt == P) begin
          rnd_done = 1'b1;
          rnd_busy = 1'b0;
        end
      end
      if (rnd_start) begin
        if (rnd_busy) busy_viol++;
        rnd_busy = 1'b1;
        pcnt     = 0;
        st_x.push_back(int'(rnd_x0));
        st_y.push_back(int'(rnd_y0));
        st_c.push_back(int'(rnd_color));
        st_cyc.push_back(cyc);
      end
      if (ack != 4'b0) begin
        ak_v.push_back(int'(ack));
        ak_cyc.push_back(cyc);
      end
      if (cb_prev && !clear_busy) cb_fall_cyc = cyc;
      cb_prev = clear_busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [3:0] c, input logic [4:0] r, input logic [8:0] k);
    req_col[4*i +: 4]   = c;
    req_row[5*i +: 5]   = r;
    req_color[9*i +: 9] = k;
    req[i]              = 1'b1;
  endtask

  typedef struct {
    int         idx;
    logic [3:0] col;
    logic [4:0] row;
    logic [8:0] color;
    int         n_start;
    int         ex;
    int         ey;
    int         exp_ack;
    int         lat;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int v, input vec_t t);
    int s0, a0, c0;
    s0 = st_x.size();
    a0 = ak_v.size();
    c0 = cyc;
    drive_req(t.idx, t.col, t.row, t.color);
    for (int n = 0; n < 40 && ak_v.size() == a0; n++) tick();
    req[t.idx] = 1'b0;
    repeat (3) tick();
    check($sformatf("v%0d_starts", v), st_x.size() - s0, t.n_start);
    if (t.n_start == 1 && st_x.size() > s0) begin
      check($sformatf("v%0d_x0", v), st_x[s0], t.ex);
      check($sformatf("v%0d_y0", v), st_y[s0], t.ey);
      check($sformatf("v%0d_color", v), st_c[s0], int'(t.color));
      check($sformatf("v%0d_start_lat", v), st_cyc[s0] - c0, 1);
    end
    check($sformatf("v%0d_ack_count", v), ak_v.size() - a0, 1);
    if (ak_v.size() > a0) begin
      check($sformatf("v%0d_ack", v), ak_v[a0], t.exp_ack);
      check($sformatf("v%0d_ack_lat", v), ak_cyc[a0] - c0, t.lat);
    end
    check($sformatf("v%0d_err", v), err, t.exp_err);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, ab;
    int exp_rr[5];

    vecs[0] = '{2, 4'd3,  5'd5,  COL_PIECE, 1, 272, 120, 4, 12, 0};
    vecs[1] = '{0, 4'd0,  5'd0,  COL_BG,    1, 200, 0,   1, 12, 0};
    vecs[2] = '{3, 4'd9,  5'd19, 9'h0AA,    1, 416, 456, 8, 12, 0};
    vecs[3] = '{1, 4'd5,  5'd10, 9'h123,    1, 320, 240, 2, 12, 0};
    vecs[4] = '{1, 4'd12, 5'd0,  9'h000,    0, 0,   0,   2, 1,  1};
    vecs[5] = '{0, 4'd0,  5'd20, 9'h000,    0, 0,   0,   1, 1,  1};
    exp_rr  = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", {ack, idle, clear_busy, err, rnd_start}, 0);
    check("rst_data", {rnd_x0, rnd_y0, rnd_color}, 0);
    resetn = 1'b1;
    repeat (2) tick();
    check("idle_after_rst", idle, 1);

    // All four requesters held: rotation from pointer 0
    s0 = st_x.size();
    a0 = ak_v.size();
    for (int i = 0; i < 4; i++) drive_req(i, 4'(i), 5'(i + 1), 9'(i + 16));
    for (int n = 0; n < 200 && ak_v.size() - a0 < 5; n++) tick();
    req = '0;
    repeat (3) tick();
    check("rr_ack_count", ak_v.size() - a0, 5);
    check("rr_start_count", st_x.size() - s0, 5);
    for (int k = 0; k < 5; k++)
      if (ak_v.size() - a0 > k) check($sformatf("rr_ack%0d", k), ak_v[a0 + k], 1 << exp_rr[k]);

    // Single-request vectors including out-of-range cells
    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Clear requested while requester 1 is waiting on the painter
    s0 = st_x.size();
    a0 = ak_v.size();
    drive_req(1, 4'd2, 5'd3, 9'h111);
    for (int n = 0; n < 20 && st_x.size() == s0; n++) tick();
    tick();
    clear_start = 1'b1;
    clear_color = COL_BG;
    drive_req(3, 4'd7, 5'd1, 9'h0F0);
    tick();
    clear_start = 1'b0;
    clear_color = '0;
    check("clr_busy_set", clear_busy, 1);
    for (int n = 0; n < 4000 && ak_v.size() - a0 < 2; n++) begin
      tick();
      if (ak_v.size() > a0) req[1] = 1'b0;
    end
    req[3] = 1'b0;
    repeat (3) tick();
    check("clr_ack_count", ak_v.size() - a0, 2);
    check("clr_start_count", st_x.size() - s0, 202);
    if (ak_v.size() - a0 == 2 && st_x.size() - s0 == 202) begin
      int bad;
      bad = 0;
      check("clr_first_ack", ak_v[a0], 2);
      check("clr_second_ack", ak_v[a0 + 1], 8);
      check("clr_req1_before_sweep", ak_cyc[a0] < st_cyc[s0 + 1], 1);
      for (int k = 0; k < 200; k++)
        if (st_x[s0 + 1 + k] != 200 + 24 * (k % 10) || st_y[s0 + 1 + k] != 24 * (k / 10) ||
            st_c[s0 + 1 + k] != int'(COL_BG)) bad++;
      check("clr_cell_errors", bad, 0);
      check("clr_last_x0", st_x[s0 + 200], 416);
      check("clr_last_y0", st_y[s0 + 200], 456);
      check("clr_busy_fall", cb_fall_cyc - st_cyc[s0 + 200], P + 1);
      check("clr_req3_x0", st_x[s0 + 201], 368);
      check("clr_req3_y0", st_y[s0 + 201], 24);
    end
    check("clr_busy_end", clear_busy, 0);

    // Reset during WAIT after pointer has moved past requester 2
    a0 = ak_v.size();
    drive_req(2, 4'd1, 5'd1, 9'h055);
    for (int n = 0; n < 40 && ak_v.size() == a0; n++) tick();
    req[2] = 1'b0;
    repeat (3) tick();
    s0 = st_x.size();
    drive_req(2, 4'd1, 5'd1, 9'h055);
    for (int n = 0; n < 20 && st_x.size() == s0; n++) tick();
    repeat (3) tick();
    ab = ak_v.size();
    resetn = 1'b0;
    tick();
    check("midrst_ctrl", {ack, idle, clear_busy, err, rnd_start}, 0);
    check("midrst_data", {rnd_x0, rnd_y0, rnd_color}, 0);
    req[2] = 1'b0;
    repeat (15) tick();
    resetn = 1'b1;
    repeat (2) tick();
    check("midrst_no_ack", ak_v.size() - ab, 0);
    check("midrst_idle", idle, 1);
    a0 = ak_v.size();
    drive_req(1, 4'd0, 5'd0, 9'h001);
    drive_req(3, 4'd0, 5'd0, 9'h003);
    for (int n = 0; n < 40 && ak_v.size() == a0; n++) tick();
    req[1] = 1'b0;
    for (int n = 0; n < 40 && ak_v.size() - a0 < 2; n++) tick();
    req[3] = 1'b0;
    repeat (3) tick();
    check("postrst_ack_count", ak_v.size() - a0, 2);
    if (ak_v.size() > a0) check("postrst_first_ack", ak_v[a0], 2);

    check("busy_violations", busy_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
